// File: rtl/lock_disp_pkg.sv
// Shared types and segment constants for the lock display scanner.
package lock_disp_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_U     = 7'b0111110;

endpackage

// File: rtl/lock_display_scanner_bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decode; non-decimal nibbles show a dash.
module bcd_to_7seg
  import lock_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0:    seg_c = 7'b0111111;
      4'd1:    seg_c = 7'b0000110;
      4'd2:    seg_c = 7'b1011011;
      4'd3:    seg_c = 7'b1001111;
      4'd4:    seg_c = 7'b1100110;
      4'd5:    seg_c = 7'b1101101;
      4'd6:    seg_c = 7'b1111101;
      4'd7:    seg_c = 7'b0000111;
      4'd8:    seg_c = 7'b1111111;
      4'd9:    seg_c = 7'b1101111;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/lock_display_scanner.sv
// Time-multiplexed 7-segment scanner with blank gaps and status overrides.
// Optional alarm blinking is enabled by defining LOCK_DISP_BLINK_EN.
module lock_display_scanner
  import lock_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [4*NUM_DIGITS-1:0]        digits_in,
  input  logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  input  logic                           mask_en,
  input  logic                           alarm,
  input  logic                           unlocked,
  output seg_t                           seg_out,
  output logic [NUM_DIGITS-1:0]          dig_en,
  output logic                           frame_tick
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned COUNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(NUM_DIGITS);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  seg_t                    seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_nxt;
  logic                    tick_nxt;
  logic                    load_c;
  logic [COUNT_W-1:0]      eff_count;
  logic [3:0]              nibble;
  seg_t                    dec_seg_c;
  seg_t                    pattern_c;
  logic                    blink_phase;

  assign load_c = (state == BLANK) && (cnt == BLANK_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BLANK;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (cnt == BLANK_LAST) state_nxt = SHOW;
      SHOW:    if (cnt == SHOW_LAST)  state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // Next values of counters and registered outputs
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    idx_nxt = idx;
    seg_nxt = seg_out;
    dig_nxt = dig_en;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt = '0;
          seg_nxt = pattern_c;
          dig_nxt = NUM_DIGITS'(1) << idx;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt = '0;
          idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          seg_nxt = SEG_BLANK;
          dig_nxt = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
        seg_nxt = SEG_BLANK;
        dig_nxt = '0;
      end
    endcase
    // Registered tick lands on the final SHOW cycle of the last digit
    tick_nxt = (state_nxt == SHOW) && (cnt_nxt == SHOW_LAST) && (idx_nxt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      seg_out    <= SEG_BLANK;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      seg_out    <= seg_nxt;
      dig_en     <= dig_nxt;
      frame_tick <= tick_nxt;
    end
  end

  // Slot pattern selection, evaluated only at the load point
  assign eff_count = (digit_count > COUNT_MAX) ? COUNT_MAX : digit_count;
  assign nibble    = 4'(digits_in >> {idx, 2'b00});

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    pattern_c = dec_seg_c;
    if (alarm)                             pattern_c = blink_phase ? SEG_BLANK : SEG_E;
    else if (unlocked)                     pattern_c = SEG_U;
    else if (COUNT_W'(idx) >= eff_count)   pattern_c = SEG_BLANK;
    else if (mask_en)                      pattern_c = SEG_DASH;
  end

`ifdef LOCK_DISP_BLINK_EN
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] frame_cnt;

  // Blink phase toggles every BLINK_FRAMES frames; a non-alarm load resets it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (load_c && !alarm) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end
`else
  logic unused_blink;
  assign blink_phase  = 1'b0;
  assign unused_blink = ^{32'(BLINK_FRAMES), load_c};
`endif

endmodule
